// File: rtl/systolic_result_collector_pkg.sv
// rtl/systolic_result_collector_pkg.sv - shared collector FSM states, array defaults and lane helper
package sa_pkg;

   localparam int SA_DATA_W   = 16;
   localparam int SA_N_COLS   = 4;
   localparam int SA_BASE_LAT = 4;

   typedef enum logic [1:0] {
      SA_COL_IDLE    = 2'd0,
      SA_COL_CAPTURE = 2'd1,
      SA_COL_FLUSH   = 2'd2
   } sa_col_state_e;

   // Lane j of a packed bottom-edge bus at the array's default geometry
   function automatic logic [SA_DATA_W-1:0] sa_lane(input logic [SA_N_COLS*SA_DATA_W-1:0] bus,
                                                    input int unsigned j);
      return bus[j*SA_DATA_W +: SA_DATA_W];
   endfunction

endpackage

// File: rtl/systolic_result_collector_if.sv
// rtl/systolic_result_collector_if.sv - aligned result-row valid/ready bus
interface systolic_result_collector_if #(
   parameter int DATA_W = sa_pkg::SA_DATA_W,
   parameter int N_COLS = sa_pkg::SA_N_COLS,
   parameter int N_ROWS = 4
) ();
   localparam int IDX_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

   logic                     out_valid;
   logic                     out_ready;
   logic [N_COLS*DATA_W-1:0] out_row;
   logic [IDX_W-1:0]         out_row_idx;

   modport master (output out_valid, output out_row, output out_row_idx, input out_ready);
   modport slave  (input out_valid, input out_row, input out_row_idx, output out_ready);
endinterface

// File: rtl/systolic_result_collector_row_fifo.sv
// rtl/systolic_result_collector_row_fifo.sv - shift-style row FIFO, head entry drives the output register
module sa_row_fifo #(
   parameter int WIDTH = 66,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             valid_o,
   output logic             drop_o
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0]    cnt_q, cnt_d, wr_idx;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_pop, do_push;

   // Next-state: a pop shifts every entry toward the head; a push lands just past the surviving entries
   always_comb begin
      do_pop  = pop_i && (cnt_q != '0);
      do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
      drop_o  = push_i && !do_push;
      wr_idx  = do_pop ? (cnt_q - CW'(1)) : cnt_q;
      cnt_d   = cnt_q;
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!do_push && do_pop) begin
         cnt_d = cnt_q - CW'(1);
      end
      mem_d = mem_q;
      if (do_pop) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            mem_d[i] = mem_q[i + 1];
         end
      end
      if (do_push) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == wr_idx) begin
               mem_d[i] = din_i;
            end
         end
      end
   end

   // Storage and occupancy; clear wins over any push or pop in the same cycle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         cnt_q <= cnt_d;
         mem_q <= mem_d;
      end
   end

   assign dout_o  = mem_q[0];
   assign valid_o = (cnt_q != '0);
endmodule

// File: rtl/systolic_result_collector.sv
// rtl/systolic_result_collector.sv - de-skews the array bottom stream into rows; optional clamp via SA_COLLECTOR_RELU_EN
module systolic_result_collector
   import sa_pkg::*;
#(
   parameter int DATA_W     = SA_DATA_W,
   parameter int N_COLS     = SA_N_COLS,
   parameter int N_ROWS     = 4,
   parameter int BASE_LAT   = SA_BASE_LAT,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     Clock,
   input  logic                     rst_n,
   input  logic                     data_clear,
   input  logic                     start,
   input  logic                     en_shift_bottom,
   input  logic [N_COLS*DATA_W-1:0] ps_bottom_in,
   systolic_result_collector_if.master out_bus,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow
);
   localparam int IDX_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
   localparam int SC_W  = $clog2(BASE_LAT + N_COLS + N_ROWS + 1);
   localparam int ROW_W = N_COLS * DATA_W;

   sa_col_state_e           state_q;
   logic [SC_W-1:0]         sc_q;
   logic                    busy_q, done_q, overflow_q;
   logic [DATA_W-1:0]       slot_q [N_COLS-1][N_ROWS];
   logic                    strobe, push, last_push, drop, fifo_valid;
   logic [ROW_W-1:0]        row_d;
   logic [IDX_W-1:0]        row_idx_d;
   logic [IDX_W+ROW_W-1:0]  fifo_dout;

   function automatic logic [DATA_W-1:0] clamp(input logic [DATA_W-1:0] v);
`ifdef SA_COLLECTOR_RELU_EN
      return v[DATA_W-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   assign strobe = en_shift_bottom && (state_q == SA_COL_CAPTURE) && !data_clear;

   // Row r completes when the last column sees it live; earlier columns come from their slots
   always_comb begin
      push      = 1'b0;
      last_push = 1'b0;
      row_d     = '0;
      row_idx_d = '0;
      for (int r = 0; r < N_ROWS; r++) begin
         if (strobe && (sc_q == SC_W'(BASE_LAT + N_COLS - 1 + r))) begin
            push      = 1'b1;
            last_push = (r == N_ROWS - 1);
            row_idx_d = IDX_W'(r);
            for (int j = 0; j < N_COLS - 1; j++) begin
               row_d[j*DATA_W +: DATA_W] = clamp(slot_q[j][r]);
            end
            row_d[(N_COLS-1)*DATA_W +: DATA_W] = clamp(ps_bottom_in[(N_COLS-1)*DATA_W +: DATA_W]);
         end
      end
   end

   // De-skew slots: column j holds row r once the strobe counter reaches BASE_LAT+j+r
   always_ff @(posedge Clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < N_COLS - 1; j++)
            for (int r = 0; r < N_ROWS; r++) slot_q[j][r] <= '0;
      end else if (data_clear) begin
         for (int j = 0; j < N_COLS - 1; j++)
            for (int r = 0; r < N_ROWS; r++) slot_q[j][r] <= '0;
      end else if (strobe) begin
         for (int j = 0; j < N_COLS - 1; j++)
            for (int r = 0; r < N_ROWS; r++)
               if (sc_q == SC_W'(BASE_LAT + j + r)) slot_q[j][r] <= ps_bottom_in[j*DATA_W +: DATA_W];
      end
   end

   // Job sequencer with registered status outputs
   always_ff @(posedge Clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SA_COL_IDLE;
         sc_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else if (data_clear) begin
         state_q    <= SA_COL_IDLE;
         sc_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            SA_COL_CAPTURE: begin
               if (strobe) begin
                  sc_q <= sc_q + SC_W'(1);
                  if (drop) overflow_q <= 1'b1;
                  if (last_push) begin
                     state_q <= SA_COL_FLUSH;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: begin
               // IDLE and FLUSH both accept a new job; busy is already low in FLUSH
               if (start) begin
                  state_q    <= SA_COL_CAPTURE;
                  sc_q       <= '0;
                  busy_q     <= 1'b1;
                  overflow_q <= 1'b0;
               end else begin
                  state_q <= SA_COL_IDLE;
               end
            end
         endcase
      end
   end

   sa_row_fifo #(
      .WIDTH (IDX_W + ROW_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (Clock),
      .rst_ni  (rst_n),
      .clear_i (data_clear),
      .push_i  (push),
      .din_i   ({row_idx_d, row_d}),
      .pop_i   (out_bus.out_ready && fifo_valid),
      .dout_o  (fifo_dout),
      .valid_o (fifo_valid),
      .drop_o  (drop)
   );

   assign out_bus.out_valid                     = fifo_valid;
   assign {out_bus.out_row_idx, out_bus.out_row} = fifo_dout;
   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = overflow_q;
endmodule

// File: tb/tb_systolic_result_collector.sv
// tb/tb_systolic_result_collector.sv - scoreboard bench for the systolic result collector
module tb_systolic_result_collector;
   localparam int DW = 16, NC = 4, NR = 4, BL = 4, FD = 2, IW = 2, RW = NC * DW;

   logic          Clock = 1'b0;
   logic          rst_n = 1'b0;
   logic          data_clear = 1'b0;
   logic          start = 1'b0;
   logic          en_shift_bottom = 1'b0;
   logic [RW-1:0] ps_bottom_in = '0;
   logic          busy, done, overflow;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic [IW+RW-1:0] exp_q [$];
   logic [IW+RW-1:0] mon_got, mon_exp;
   logic [DW-1:0]    mat [NR][NC];

   systolic_result_collector_if #(.DATA_W(DW), .N_COLS(NC), .N_ROWS(NR)) bus ();

   systolic_result_collector #(
      .DATA_W(DW), .N_COLS(NC), .N_ROWS(NR), .BASE_LAT(BL), .FIFO_DEPTH(FD)
   ) dut (
      .Clock           (Clock),
      .rst_n           (rst_n),
      .data_clear      (data_clear),
      .start           (start),
      .en_shift_bottom (en_shift_bottom),
      .ps_bottom_in    (ps_bottom_in),
      .out_bus         (bus),
      .busy            (busy),
      .done            (done),
      .overflow        (overflow)
   );

   always #5 Clock = ~Clock;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] model_lane(input logic [DW-1:0] v);
`ifdef SA_COLLECTOR_RELU_EN
      return v[DW-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   task automatic fill_mat(input bit pattern);
      for (int r = 0; r < NR; r++)
         for (int j = 0; j < NC; j++)
            mat[r][j] = pattern ? DW'(256 * (r + 1) + j) : DW'($urandom);
   endtask

   task automatic expect_rows(input int n);
      logic [RW-1:0] row;
      for (int r = 0; r < n; r++) begin
         for (int j = 0; j < NC; j++) row[j*DW +: DW] = model_lane(mat[r][j]);
         exp_q.push_back({IW'(r), row});
      end
   endtask

   // Skewed bottom-edge view of the matrix: lane j carries row s-BL-j inside its window
   function automatic logic [RW-1:0] lanes_for(input int s, input bit dead);
      logic [RW-1:0] v;
      for (int j = 0; j < NC; j++) begin
         int r;
         r = s - BL - j;
         if (r >= 0 && r < NR) v[j*DW +: DW] = mat[r][j];
         else                  v[j*DW +: DW] = dead ? 16'hDEAD : DW'($urandom);
      end
      return v;
   endfunction

   task automatic send_strobes(input int n, input int gap_max, input int ready_at,
                               input int start_at, input bit dead);
      for (int s = 0; s < n; s++) begin
         if (s == ready_at) bus.out_ready = 1'b1;
         repeat ($urandom_range(gap_max, 0)) begin
            en_shift_bottom = 1'b0;
            ps_bottom_in    = {$urandom, $urandom};
            tick();
         end
         en_shift_bottom = 1'b1;
         ps_bottom_in    = lanes_for(s, dead);
         start           = (s == start_at);
         tick();
         en_shift_bottom = 1'b0;
         start           = 1'b0;
      end
   endtask

   task automatic begin_job(input string name);
      done_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({name, "_busy_rise"}, 80'(busy), 80'(1));
   endtask

   task automatic wait_drain(input string name, input int exp_done);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && k < 200) begin
         tick();
         k++;
      end
      chk({name, "_drain"}, 80'(exp_q.size()), 80'(0));
      repeat (3) tick();
      chk({name, "_done_count"}, 80'(done_cnt), 80'(exp_done));
      chk({name, "_busy_end"}, 80'(busy), 80'(0));
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_out_valid"}, 80'(bus.out_valid), 80'(0));
      chk({name, "_out_row"}, 80'(bus.out_row), 80'(0));
      chk({name, "_out_row_idx"}, 80'(bus.out_row_idx), 80'(0));
      chk({name, "_busy"}, 80'(busy), 80'(0));
      chk({name, "_done"}, 80'(done), 80'(0));
      chk({name, "_overflow"}, 80'(overflow), 80'(0));
   endtask

   // Monitor: every accepted row is popped from the scoreboard; done must coincide with busy low
   always @(negedge Clock) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         checks++;
         mon_got = {bus.out_row_idx, bus.out_row};
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_row actual=%h required=none", mon_got);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               errors++;
               $display("FAIL row_scoreboard actual=%h required=%h", mon_got, mon_exp);
            end
         end
      end
      if (rst_n && done) begin
         checks++;
         done_cnt++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL done_busy actual=%b required=0", busy);
         end
      end
   end

   initial begin
      int seen;
      bus.out_ready = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      // Diagonal stream with marker values outside each lane's window
      fill_mat(1'b1);
      bus.out_ready = 1'b1;
      begin_job("diag");
      expect_rows(NR);
      send_strobes(16, 0, -1, -1, 1'b1);
      wait_drain("diag", 1);

      // Backpressure: two rows fit, rows 2 and 3 are dropped
      fill_mat(1'b0);
      bus.out_ready = 1'b0;
      begin_job("bp");
      expect_rows(2);
      send_strobes(12, 0, -1, -1, 1'b0);
      chk("bp_overflow", 80'(overflow), 80'(1));
      chk("bp_valid_held", 80'(bus.out_valid), 80'(1));
      chk("bp_head_idx", 80'(bus.out_row_idx), 80'(0));
      bus.out_ready = 1'b1;
      wait_drain("bp", 1);
      chk("bp_overflow_sticky", 80'(overflow), 80'(1));

      // Full FIFO with a pop on the same edge as the push of row 2
      fill_mat(1'b0);
      bus.out_ready = 1'b0;
      begin_job("fullpop");
      chk("fullpop_overflow_cleared", 80'(overflow), 80'(0));
      expect_rows(NR);
      send_strobes(12, 0, 9, -1, 1'b0);
      chk("fullpop_no_overflow", 80'(overflow), 80'(0));
      wait_drain("fullpop", 1);

      // Gapped strobes of the diagonal pattern with a stray start mid-job
      fill_mat(1'b1);
      bus.out_ready = 1'b1;
      begin_job("gap");
      expect_rows(NR);
      send_strobes(12, 3, -1, 5, 1'b1);
      wait_drain("gap", 1);

      // Random matrices, random gaps
      for (int t = 0; t < 3; t++) begin
         fill_mat(1'b0);
         begin_job("rand");
         expect_rows(NR);
         send_strobes(12, 2, -1, -1, 1'b0);
         wait_drain("rand", 1);
      end

      // Sign-bit lanes, including one on the live last column
      fill_mat(1'b0);
      mat[0][0] = 16'hFFF0;
      mat[1][1] = 16'h7FF0;
      mat[2][3] = 16'h8000;
      begin_job("relu");
      expect_rows(NR);
      send_strobes(12, 0, -1, -1, 1'b0);
      wait_drain("relu", 1);

      // data_clear after row 1 is pushed discards everything
      fill_mat(1'b0);
      bus.out_ready = 1'b0;
      begin_job("clr");
      send_strobes(9, 0, -1, -1, 1'b0);
      chk("clr_rows_pending", 80'(bus.out_valid), 80'(1));
      data_clear = 1'b1;
      tick();
      data_clear = 1'b0;
      chk("clr_valid", 80'(bus.out_valid), 80'(0));
      chk("clr_busy", 80'(busy), 80'(0));
      chk("clr_overflow", 80'(overflow), 80'(0));
      send_strobes(4, 0, -1, -1, 1'b0);
      bus.out_ready = 1'b1;
      repeat (5) tick();
      chk("clr_stays_empty", 80'(bus.out_valid), 80'(0));
      chk("clr_no_done", 80'(done_cnt), 80'(0));

      // Asynchronous reset mid-job
      fill_mat(1'b0);
      bus.out_ready = 1'b0;
      begin_job("rst");
      send_strobes(9, 0, -1, -1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_async");
      tick();
      tick();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      seen = 0;
      for (int s = 0; s < 12; s++) begin
         en_shift_bottom = 1'b1;
         ps_bottom_in    = lanes_for(s, 1'b0);
         tick();
         if (bus.out_valid) seen++;
      end
      en_shift_bottom = 1'b0;
      repeat (5) begin
         tick();
         if (bus.out_valid) seen++;
      end
      chk("rst_no_rows_after", 80'(seen), 80'(0));
      chk("rst_no_done", 80'(done_cnt), 80'(0));

      chk("final_scoreboard_empty", 80'(exp_q.size()), 80'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
